fp_addsub_param: RTL
====================

// Module: fp_addsub_param
// PURPOSE
//   Parametrised IEEE-754-style floating-point add/subtract unit with valid/ready handshake.
//   Next generation of the single-precision adder, generalised in exponent and fraction width.
//   Adds a run-time add/sub select, round-to-nearest-even, output back-pressure and exception flags.
//   Sits behind the operand/issue stage; takes packed operands directly and unpacks them internally.
// PARAMETERS
//   EXP_W   8   exponent field width (>=3)
//   FRAC_W  23  stored fraction width (>=2); total word width W = 1+EXP_W+FRAC_W
// PORTS
//   clk_i        in   1  clock, all state updates on rising edge
//   rst_ni       in   1  asynchronous active-low reset
//   valid_i      in   1  operands valid
//   ready_o      out  1  unit can accept operands (high only in IDLE)
//   sub_i        in   1  0: z=x+y, 1: z=x-y (sampled with operands)
//   x_i          in   W  operand x, packed {sign,exp,frac}
//   y_i          in   W  operand y, packed
//   valid_o      out  1  result valid; held until ready_i
//   ready_i      in   1  downstream accepts result
//   z_o          out  W  packed result
//   inf_o        out  1  result is +/-infinity
//   nan_o        out  1  result is NaN
//   overflow_o   out  1  finite operands rounded past max normal
//   underflow_o  out  1  nonzero result below min normal, flushed to zero
// BEHAVIOUR
//   Reset: state=IDLE, ready_o=1, valid_o=0, z_o=0, all flags=0; an in-flight operation is discarded.
//   Accept: valid_i&&ready_o on a rising edge latches x_i, y_i and sub_i; ready_o drops the next cycle.
//   FSM: IDLE->UNPACK->ALIGN->ADD->NORM->ROUND->DONE. Each state lasts 1 cycle except DONE.
//     valid_o rises exactly 5 cycles after the accept edge.
//   DONE: z_o and flags are held stable while ready_i=0.
//     On valid_o&&ready_i the FSM goes to IDLE; ready_o=1 on the next cycle (no same-cycle re-accept).
//   UNPACK: y sign is inverted when sub_i=1.
//     Hidden bit = (exp!=0). Subnormal inputs (exp=0) are treated as signed zero (flush-to-zero).
//   ALIGN: the smaller-magnitude operand is right-shifted by the exponent difference into a FRAC_W+4 bit datapath.
//     Datapath = hidden bit, fraction, guard, round, sticky. Sticky ORs all shifted-out bits.
//     A shift >= FRAC_W+3 leaves sticky only.
//   ADD: add when the signs match, else subtract the smaller magnitude from the larger (no negative intermediate).
//     Result sign = sign of the larger magnitude.
//   NORM: carry-out -> shift right 1 (sticky keeps the lost bit) and exp+1.
//     Otherwise a leading-zero count gives a single-cycle left shift and exp-lzc.
//     exp-lzc<1 -> underflow: flush to signed zero, underflow_o=1.
//   ROUND: RNE. Increment if G&&(R|S|LSB). Mantissa overflow from rounding -> exp+1.
//     Exp reaching 2^EXP_W-1 -> overflow: z=signed inf, inf_o=1, overflow_o=1.
//   Specials (resolved in UNPACK, value carried to DONE, same latency):
//     NaN operand, or inf+(-inf) after sub adjustment -> canonical NaN: sign 0, exp all 1, frac MSB 1, nan_o=1.
//     Exactly one inf -> that inf with adjusted sign, inf_o=1.
//     Exact zero sum of opposite-sign operands -> +0. (-0)+(-0) -> -0.
//   Flags are mutually consistent: overflow_o implies inf_o; nan_o excludes all others.
// TESTING
//   1) x=3fc00000, y=4500001a, sub=0 -> z=4500181a, flags 0, valid_o 5 cycles after accept.
//   2) x=3f000000, y=3ee00000, sub=1 -> z=3d800000 (normalising left shift by 3).
//   3) x=3f800000, y=33800000, sub=0 (tie) -> z=3f800000. y=33c00000 -> z=3f800001.
//   4) x=7f800000, y=ff800000, sub=0 -> z=7fc00000, nan_o=1. x=7f7fffff, y=7f7fffff -> z=7f800000, inf_o=overflow_o=1.
//   5) x=40490fdb, y=40490fdb, sub=1 -> z=00000000. ready_i low 10 cycles: z_o/valid_o stable, ready_o=0.
//   6) EXP_W=5, FRAC_W=10: 3c00+3c00 -> 4000. rst_ni pulsed low during ALIGN -> valid_o never asserts, ready_o=1.

Source files
------------

// File: rtl/fp_addsub_param_if.sv
// Operand/result channel of the floating-point add/subtract unit.
// Both directions follow valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface fp_addsub_param_if #(
  parameter int W = 32
);
  logic         valid_i;
  logic         ready_o;
  logic         sub_i;
  logic [W-1:0] x_i;
  logic [W-1:0] y_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] z_o;
  logic         inf_o;
  logic         nan_o;
  logic         overflow_o;
  logic         underflow_o;

  modport slave (
    input  valid_i, sub_i, x_i, y_i, ready_i,
    output ready_o, valid_o, z_o, inf_o, nan_o, overflow_o, underflow_o
  );

  modport master (
    output valid_i, sub_i, x_i, y_i, ready_i,
    input  ready_o, valid_o, z_o, inf_o, nan_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/fp_addsub_param.sv
// Multi-cycle parametrised floating-point add/subtract with round-to-nearest-even and flush-to-zero.
// One operation in flight; the stages UNPACK..ROUND each take one cycle, DONE holds the result.
module fp_addsub_param #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  fp_addsub_param_if.slave    bus,
  output logic [2:0]          state_o
);
  localparam int W    = 1 + EXP_W + FRAC_W;
  localparam int M    = FRAC_W + 4;
  localparam int LZ_W = $clog2(M) + 1;
  localparam int EW1  = EXP_W + 1;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t              r_state;
  logic [W-1:0]        r_x, r_y;
  logic                r_sub;
  logic                r_sa, r_sb, r_nan, r_inf, r_inf_s, r_s, r_nuf;
  logic [EXP_W-1:0]    r_ea, r_eb;
  logic [FRAC_W:0]     r_ma, r_mb;
  logic [M-1:0]        r_ma_al, r_mb_al, r_nm;
  logic [M:0]          r_sum;
  logic [EW1-1:0]      r_ne;

  assign state_o = r_state;

  // UNPACK: field split, special detection, magnitude ordering (subnormals count as zero)
  logic [EXP_W-1:0]  w_ex, w_ey;
  logic [FRAC_W-1:0] w_fx, w_fy;
  logic              w_sx, w_sy, w_x_nan, w_y_nan, w_x_inf, w_y_inf, w_swap;
  logic [W-2:0]      w_kx, w_ky;
  logic [FRAC_W:0]   w_mx, w_my;

  assign w_sx    = r_x[W-1];
  assign w_sy    = r_y[W-1] ^ r_sub;
  assign w_ex    = r_x[W-2:FRAC_W];
  assign w_ey    = r_y[W-2:FRAC_W];
  assign w_fx    = r_x[FRAC_W-1:0];
  assign w_fy    = r_y[FRAC_W-1:0];
  assign w_x_nan = (w_ex == EXP_MAX) && (w_fx != '0);
  assign w_y_nan = (w_ey == EXP_MAX) && (w_fy != '0);
  assign w_x_inf = (w_ex == EXP_MAX) && (w_fx == '0);
  assign w_y_inf = (w_ey == EXP_MAX) && (w_fy == '0);
  assign w_kx    = (w_ex == '0) ? '0 : {w_ex, w_fx};
  assign w_ky    = (w_ey == '0) ? '0 : {w_ey, w_fy};
  assign w_swap  = w_ky > w_kx;
  assign w_mx    = (w_ex == '0) ? '0 : {1'b1, w_fx};
  assign w_my    = (w_ey == '0) ? '0 : {1'b1, w_fy};

  // ALIGN: shifts of M or more fall out entirely and survive only in the sticky bit
  logic [EXP_W-1:0] w_d;
  logic [M-1:0]     w_bext, w_mask, w_sh, w_b_al;
  assign w_d    = r_ea - r_eb;
  assign w_bext = {r_mb, 3'b000};
  assign w_mask = ~({M{1'b1}} << w_d);
  assign w_sh   = w_bext >> w_d;
  assign w_b_al = {w_sh[M-1:1], w_sh[0] | (|(w_bext & w_mask))};

  // ADD: b is never larger than a, so the difference cannot go negative
  logic [M:0] w_sum;
  logic       w_sum_s;
  assign w_sum   = (r_sa == r_sb) ? ({1'b0, r_ma_al} + {1'b0, r_mb_al})
                                  : ({1'b0, r_ma_al} - {1'b0, r_mb_al});
  assign w_sum_s = (w_sum == '0) ? (r_sa & r_sb) : r_sa;

  // NORM
  logic [LZ_W-1:0] w_lzc;
  logic            w_found, w_carry, w_n_uf;
  logic [M-1:0]    w_n_m;
  logic [EW1-1:0]  w_n_e;
  always_comb begin
    w_lzc   = '0;
    w_found = 1'b0;
    for (int i = M - 1; i >= 0; i--) begin
      if (!w_found) begin
        if (r_sum[i]) w_found = 1'b1;
        else          w_lzc   = w_lzc + 1'b1;
      end
    end
  end
  assign w_carry = r_sum[M];
  assign w_n_uf  = !w_carry && (r_sum != '0) && (32'(w_lzc) >= 32'(r_ea));
  assign w_n_m   = w_carry ? {r_sum[M:2], r_sum[1] | r_sum[0]} : (r_sum[M-1:0] << w_lzc);
  assign w_n_e   = w_carry ? ({1'b0, r_ea} + 1'b1) : ({1'b0, r_ea} - EW1'(w_lzc));

  // ROUND: an all-zero mantissa after normalisation means an exact zero result
  logic              w_inc, w_ovf, w_zero;
  logic [FRAC_W+1:0] w_rm;
  logic [EW1-1:0]    w_re;
  logic [W-1:0]      w_z;
  logic [3:0]        w_flags;
  assign w_inc  = r_nm[2] & (r_nm[1] | r_nm[0] | r_nm[3]);
  assign w_rm   = {1'b0, r_nm[M-1:3]} + (FRAC_W+2)'(w_inc);
  assign w_re   = r_ne + EW1'(w_rm[FRAC_W+1]);
  assign w_ovf  = w_re >= {1'b0, EXP_MAX};
  assign w_zero = ~|w_rm[FRAC_W+1:FRAC_W];

  always_comb begin
    w_z     = {r_s, w_re[EXP_W-1:0], w_rm[FRAC_W-1:0]};
    w_flags = 4'b0000;  // {inf, nan, overflow, underflow}
    if (r_nan) begin
      w_z     = {1'b0, EXP_MAX, 1'b1, {(FRAC_W-1){1'b0}}};
      w_flags = 4'b0100;
    end else if (r_inf) begin
      w_z     = {r_inf_s, EXP_MAX, {FRAC_W{1'b0}}};
      w_flags = 4'b1000;
    end else if (r_nuf) begin
      w_z     = {r_s, {(W-1){1'b0}}};
      w_flags = 4'b0001;
    end else if (w_zero) begin
      w_z     = {r_s, {(W-1){1'b0}}};
    end else if (w_ovf) begin
      w_z     = {r_s, EXP_MAX, {FRAC_W{1'b0}}};
      w_flags = 4'b1010;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      bus.ready_o <= 1'b1;
      bus.valid_o <= 1'b0;
      bus.z_o <= '0;
      {bus.inf_o, bus.nan_o, bus.overflow_o, bus.underflow_o} <= 4'b0000;
      r_x <= '0; r_y <= '0; r_sub <= 1'b0;
      r_sa <= 1'b0; r_sb <= 1'b0; r_ea <= '0; r_eb <= '0; r_ma <= '0; r_mb <= '0;
      r_nan <= 1'b0; r_inf <= 1'b0; r_inf_s <= 1'b0;
      r_ma_al <= '0; r_mb_al <= '0; r_sum <= '0; r_s <= 1'b0;
      r_nm <= '0; r_ne <= '0; r_nuf <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.valid_i) begin
          r_x <= bus.x_i; r_y <= bus.y_i; r_sub <= bus.sub_i;
          bus.ready_o <= 1'b0;
          r_state <= S_UNPACK;
        end
        S_UNPACK: begin
          r_sa <= w_swap ? w_sy : w_sx;  r_sb <= w_swap ? w_sx : w_sy;
          r_ea <= w_swap ? w_ey : w_ex;  r_eb <= w_swap ? w_ex : w_ey;
          r_ma <= w_swap ? w_my : w_mx;  r_mb <= w_swap ? w_mx : w_my;
          r_nan   <= w_x_nan || w_y_nan || (w_x_inf && w_y_inf && (w_sx != w_sy));
          r_inf   <= w_x_inf || w_y_inf;
          r_inf_s <= w_x_inf ? w_sx : w_sy;
          r_state <= S_ALIGN;
        end
        S_ALIGN: begin
          r_ma_al <= {r_ma, 3'b000};
          r_mb_al <= w_b_al;
          r_state <= S_ADD;
        end
        S_ADD: begin
          r_sum <= w_sum; r_s <= w_sum_s;
          r_state <= S_NORM;
        end
        S_NORM: begin
          r_nm <= w_n_m; r_ne <= w_n_e; r_nuf <= w_n_uf;
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          bus.z_o <= w_z;
          {bus.inf_o, bus.nan_o, bus.overflow_o, bus.underflow_o} <= w_flags;
          bus.valid_o <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: if (bus.ready_i) begin
          bus.valid_o <= 1'b0;
          bus.ready_o <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
